crtc_config: RTL and testbench

//  Wishbone register set that configures the CRT controller: holds the eight
//  10-bit timing values, double-buffers them so new timings take effect only
//  at a frame boundary, and raises an interrupt on VSYNC rise or raster line.

---
 rtl/crtc_config.sv | 142 ++++++++++++++
 tb/tb_crtc_config.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/crtc_config.sv
// Wishbone register set for the CRT controller: shadow/active timing registers
// committed at frame end, plus VSYNC/raster interrupt. Option: CRTC_RASTER_IRQ_EN.
module crtc_config (
  input  logic        dotclk_i,
  input  logic        reset_ni,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  adr_i,
  input  logic [15:0] dat_i,
  output logic [15:0] dat_o,
  output logic        ack_o,
  input  logic [9:0]  x_i,
  input  logic [9:0]  y_i,
  input  logic        vsync_i,
  output logic [9:0]  htotal_o,
  output logic [9:0]  vtotal_o,
  output logic [9:0]  hsstart_o,
  output logic [9:0]  vsstart_o,
  output logic [9:0]  hvstart_o,
  output logic [9:0]  hvend_o,
  output logic [9:0]  vvstart_o,
  output logic [9:0]  vvend_o,
  output logic        irq_o
);

  localparam int unsigned TW   = 10;
  localparam int unsigned NREG = 8;
  localparam logic [TW-1:0] DEF [NREG] = '{10'd799, 10'd524, 10'd704, 10'd523,
                                           10'd0,   10'd640, 10'd524, 10'd479};

  logic [TW-1:0] r_shadow [NREG];
  logic [TW-1:0] r_active [NREG];
  logic          r_pending;
  logic [1:0]    r_status;
  logic [1:0]    r_irqen;
  logic          r_vsync_q;
  logic          r_ack;
  logic [15:0]   r_dat;
  logic          r_irq;
`ifdef CRTC_RASTER_IRQ_EN
  logic [TW-1:0] r_raster;
`endif

  logic          w_acc;
  logic          w_wr;
  logic          w_frame_end;
  logic [1:0]    w_set;
  logic [1:0]    w_w1c;
  logic [15:0]   w_rdata;
  logic          w_unused_dat;

  assign w_acc        = cyc_i & stb_i & ~r_ack;
  assign w_wr         = w_acc & we_i;
  assign w_frame_end  = (x_i == r_active[0]) & (y_i == r_active[1]);
  assign w_unused_dat = &{1'b0, dat_i[15:10]};

  // Event sources and write-one-to-clear mask for STATUS
  always_comb begin
    w_set    = 2'b00;
    w_w1c    = 2'b00;
    w_set[0] = vsync_i & ~r_vsync_q;
`ifdef CRTC_RASTER_IRQ_EN
    w_set[1] = (x_i == r_active[0]) & (y_i == r_raster);
    if (w_wr && adr_i == 4'd10) w_w1c = dat_i[1:0];
`else
    if (w_wr && adr_i == 4'd10) w_w1c[0] = dat_i[0];
`endif
  end

  always_comb begin
    w_rdata = '0;
    case (adr_i)
      4'd0, 4'd1, 4'd2, 4'd3,
      4'd4, 4'd5, 4'd6, 4'd7: w_rdata = 16'(r_shadow[adr_i[2:0]]);
      4'd8:                   w_rdata = 16'(r_pending);
`ifdef CRTC_RASTER_IRQ_EN
      4'd9:                   w_rdata = 16'(r_raster);
`endif
      4'd10:                  w_rdata = 16'(r_status);
      4'd11:                  w_rdata = 16'(r_irqen);
      4'd12:                  w_rdata = 16'(y_i);
      4'd13:                  w_rdata = 16'(x_i);
      default:                w_rdata = '0;
    endcase
  end

  always_ff @(posedge dotclk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_shadow[i] <= DEF[i];
        r_active[i] <= DEF[i];
      end
      r_pending <= 1'b0;
      r_status  <= 2'b00;
      r_irqen   <= 2'b00;
      r_vsync_q <= 1'b0;
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_irq     <= 1'b0;
`ifdef CRTC_RASTER_IRQ_EN
      r_raster  <= '0;
`endif
    end else begin
      r_ack     <= w_acc;
      r_dat     <= w_acc ? w_rdata : 16'd0;
      r_vsync_q <= vsync_i;
      r_irq     <= |(r_status & r_irqen);
      r_status  <= (r_status & ~w_w1c) | w_set;

      if (w_wr && !adr_i[3]) r_shadow[adr_i[2:0]] <= dat_i[TW-1:0];

      // Copy takes the pre-edge shadow values; a request during pending is absorbed
      if (r_pending && w_frame_end) begin
        for (int i = 0; i < int'(NREG); i++) r_active[i] <= r_shadow[i];
        r_pending <= 1'b0;
      end else if (w_wr && adr_i == 4'd8 && dat_i[0]) begin
        r_pending <= 1'b1;
      end

`ifdef CRTC_RASTER_IRQ_EN
      if (w_wr && adr_i == 4'd9)  r_raster <= dat_i[TW-1:0];
      if (w_wr && adr_i == 4'd11) r_irqen  <= dat_i[1:0];
`else
      if (w_wr && adr_i == 4'd11) r_irqen  <= {1'b0, dat_i[0]};
`endif
    end
  end

  assign dat_o     = r_dat;
  assign ack_o     = r_ack;
  assign irq_o     = r_irq;
  assign htotal_o  = r_active[0];
  assign vtotal_o  = r_active[1];
  assign hsstart_o = r_active[2];
  assign vsstart_o = r_active[3];
  assign hvstart_o = r_active[4];
  assign hvend_o   = r_active[5];
  assign vvstart_o = r_active[6];
  assign vvend_o   = r_active[7];

endmodule

// File: tb/tb_crtc_config.sv
// Directed bench for crtc_config: reset defaults, frame-end commit, IRQ and reset abort.
module tb_crtc_config;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  adr = '0;
  logic [15:0] dat = '0;
  logic [15:0] dat_o;
  logic        ack_o;
  logic [9:0]  x = '0, y = '0;
  logic        vsync = 1'b0;
  logic [9:0]  htotal, vtotal, hsstart, vsstart, hvstart, hvend, vvstart, vvend;
  logic        irq;
  logic [15:0] rd_tmp;

  int n_pass  = 0;
  int n_total = 0;

`ifdef CRTC_RASTER_IRQ_EN
  localparam logic RAS = 1'b1;
`else
  localparam logic RAS = 1'b0;
`endif

  crtc_config dut (
    .dotclk_i(clk), .reset_ni(rst_n),
    .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr), .dat_i(dat),
    .dat_o(dat_o), .ack_o(ack_o),
    .x_i(x), .y_i(y), .vsync_i(vsync),
    .htotal_o(htotal), .vtotal_o(vtotal), .hsstart_o(hsstart), .vsstart_o(vsstart),
    .hvstart_o(hvstart), .hvend_o(hvend), .vvstart_o(vvstart), .vvend_o(vvend),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic bus_drive(input logic w, input logic [3:0] a, input logic [15:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d;
  endtask

  // Sample the acked cycle, release the bus, then let ack drop
  task automatic bus_finish(output logic [15:0] r);
    @(posedge clk); #1;
    chk("ack", 16'(ack_o), 16'd1);
    r = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk); bus_drive(1'b1, a, d); bus_finish(rd_tmp);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    logic [15:0] r;
    @(negedge clk); bus_drive(1'b0, a, 16'd0); bus_finish(r);
    chk(tag, r, exp);
  endtask

  task automatic frame(input logic [9:0] fx, input logic [9:0] fy);
    @(negedge clk); x = fx; y = fy;
    @(posedge clk); #1; x = '0; y = '0;
  endtask

  initial begin
    // Reset defaults, during and after reset
    #12;
    chk("rst_htotal", 16'(htotal), 16'd799);
    chk("rst_vtotal", 16'(vtotal), 16'd524);
    chk("rst_hsstart", 16'(hsstart), 16'd704);
    chk("rst_vsstart", 16'(vsstart), 16'd523);
    chk("rst_hvstart", 16'(hvstart), 16'd0);
    chk("rst_hvend", 16'(hvend), 16'd640);
    chk("rst_vvstart", 16'(vvstart), 16'd524);
    chk("rst_vvend", 16'(vvend), 16'd479);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_irq", 16'(irq), 16'd0);
    chk("rel_ack", 16'(ack_o), 16'd0);
    chk("rel_htotal", 16'(htotal), 16'd799);

    // Shadow write without commit leaves active untouched
    wr(4'd0, 16'd999);
    frame(10'd799, 10'd524);
    frame(10'd799, 10'd524);
    chk("nocommit_htotal", 16'(htotal), 16'd799);
    rd_chk("nocommit_ctrl", 4'd8, 16'd0);
    rd_chk("shadow_htotal", 4'd0, 16'd999);

    // Commit at frame end
    wr(4'd8, 16'd1);
    rd_chk("pending_set", 4'd8, 16'd1);
    @(negedge clk); x = 10'd799; y = 10'd524;
    chk("pre_commit_htotal", 16'(htotal), 16'd799);
    @(posedge clk); #1; x = '0; y = '0;
    chk("commit_htotal", 16'(htotal), 16'd999);
    rd_chk("pending_clear", 4'd8, 16'd0);

    // Commit request on the frame-end edge defers to the next frame end
    wr(4'd1, 16'd600);
    @(negedge clk); bus_drive(1'b1, 4'd8, 16'd1); x = 10'd999; y = 10'd524;
    @(posedge clk); #1; x = '0; y = '0;
    chk("ack", 16'(ack_o), 16'd1);
    chk("req_on_fe_vtotal", 16'(vtotal), 16'd524);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rd_chk("req_on_fe_pending", 4'd8, 16'd1);
    frame(10'd999, 10'd524);
    chk("deferred_vtotal", 16'(vtotal), 16'd600);

    // Shadow write on commit edge: old value is copied
    wr(4'd8, 16'd1);
    @(negedge clk); bus_drive(1'b1, 4'd2, 16'd100); x = 10'd999; y = 10'd600;
    bus_finish(rd_tmp);
    x = '0; y = '0;
    chk("wr_on_commit_hsstart", 16'(hsstart), 16'd704);
    rd_chk("wr_on_commit_shadow", 4'd2, 16'd100);
    rd_chk("wr_on_commit_pending", 4'd8, 16'd0);
    frame(10'd999, 10'd600);
    chk("no_recommit_hsstart", 16'(hsstart), 16'd704);

    // VSYNC interrupt, W1C, and set-wins-over-clear
    wr(4'd11, 16'd1);
    @(negedge clk); vsync = 1'b1;
    @(posedge clk); #1;
    chk("irq_lag", 16'(irq), 16'd0);
    @(posedge clk); #1;
    chk("irq_vsync", 16'(irq), 16'd1);
    rd_chk("status_vsync", 4'd10, 16'd1);
    wr(4'd10, 16'd1);
    chk("irq_after_w1c", 16'(irq), 16'd0);
    rd_chk("status_after_w1c", 4'd10, 16'd0);
    @(negedge clk); vsync = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); bus_drive(1'b1, 4'd10, 16'd1); vsync = 1'b1;
    bus_finish(rd_tmp);
    chk("irq_set_wins", 16'(irq), 16'd1);
    rd_chk("status_set_wins", 4'd10, 16'd1);

    // Raster compare (present only with the option)
    wr(4'd10, 16'd3);
    wr(4'd9, 16'd100);
    wr(4'd11, 16'd2);
    rd_chk("raster_rd", 4'd9, RAS ? 16'd100 : 16'd0);
    rd_chk("irqen_rd", 4'd11, RAS ? 16'd2 : 16'd0);
    rd_chk("status_cleared", 4'd10, 16'd0);
    chk("irq_cleared", 16'(irq), 16'd0);
    frame(10'd999, 10'd100);
    rd_chk("status_raster", 4'd10, RAS ? 16'd2 : 16'd0);
    chk("irq_raster", 16'(irq), RAS ? 16'd1 : 16'd0);

    // Reset in the middle of a write with a commit pending
    wr(4'd0, 16'd500);
    wr(4'd8, 16'd1);
    rd_chk("pre_reset_pending", 4'd8, 16'd1);
    @(negedge clk); bus_drive(1'b1, 4'd0, 16'd123);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_htotal", 16'(htotal), 16'd799);
    chk("reset_vtotal", 16'(vtotal), 16'd524);
    chk("reset_irq", 16'(irq), 16'd0);
    @(posedge clk); #1;
    chk("reset_no_ack", 16'(ack_o), 16'd0);
    chk("reset_dat", dat_o, 16'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; vsync = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    rd_chk("post_reset_pending", 4'd8, 16'd0);
    rd_chk("post_reset_shadow", 4'd0, 16'd799);
    rd_chk("post_reset_irqen", 4'd11, 16'd0);
    rd_chk("unmapped_rd", 4'd14, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
